// File: rtl/dma_command_unit.sv
// -----------------------------------------------------------------------------
// dma_command_unit
//
// Command sequencer sitting in front of the JTAG DMA engine. A single-word
// read or write command is accepted, write data is staged into word 0 of the
// shared buffer, and the DMA is kicked with a one-cycle data-ready (write) or
// read-ready (read) pulse. Completion is detected by snooping the arbiter and
// the shared bus. Every accepted command yields exactly one response carrying
// read data and a status code (00 ok, 01 bus error, 10 timeout).
//
// Ports
//   clock, reset                    clock; asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_read, cmd_address,
//   cmd_byte_enable, cmd_wdata      command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_status           response payload
//   buf_address, buf_wdata, buf_we  write port into the shared word buffer
//   dma_data_ready, dma_read_ready  one-cycle triggers to the DMA
//   dma_address, dma_byte_enable    latched command address / byte lanes
//   dma_buf_we, dma_buf_wdata       snoop of the DMA's buffer write port
//   dma_request, dma_granted        snoop of the DMA's arbiter handshake
//   bus_end_transaction, bus_error  shared bus status
// -----------------------------------------------------------------------------
module dma_command_unit #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_read,
   input  logic [31:0] cmd_address,
   input  logic [3:0]  cmd_byte_enable,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_status,
   output logic [8:0]  buf_address,
   output logic [31:0] buf_wdata,
   output logic        buf_we,
   output logic        dma_data_ready,
   output logic        dma_read_ready,
   output logic [31:0] dma_address,
   output logic [3:0]  dma_byte_enable,
   input  logic        dma_buf_we,
   input  logic [31:0] dma_buf_wdata,
   input  logic        dma_request,
   input  logic        dma_granted,
   input  logic        bus_end_transaction,
   input  logic        bus_error
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      BUF_WRITE = 3'd1,
      ISSUE     = 3'd2,
      WAIT_WR   = 3'd3,
      WAIT_RD   = 3'd4,
      RESPOND   = 3'd5
   } state_t;

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_BUS_ERR = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

   // The counter holds k-1 during the k-th wait cycle; the timeout fires in
   // the cycle where it is about to reach TIMEOUT_CYCLES, so the response
   // appears TIMEOUT_CYCLES+1 cycles after ISSUE.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_reg, state_next;
   logic        read_reg;
   logic [31:0] address_reg;
   logic [3:0]  byte_enable_reg;
   logic [31:0] wdata_reg;
   logic        owned_reg, owned_next;
   logic [15:0] wd_count_reg, wd_count_next;
   logic [31:0] rsp_rdata_reg, rsp_rdata_next;
   logic [1:0]  rsp_status_reg, rsp_status_next;

   logic accept;
   logic timeout_hit;
   logic completion;

   assign accept      = cmd_valid && (state_reg == IDLE);
   assign timeout_hit = (wd_count_reg >= TIMEOUT_LAST);

   // Completion event for the current wait state. A foreign end_transaction
   // (arbiter has not granted us) must not complete a write.
   always_comb begin
      completion = 1'b0;
      if (state_reg == WAIT_WR) completion = bus_end_transaction && owned_reg;
      if (state_reg == WAIT_RD) completion = dma_buf_we;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         read_reg        <= 1'b0;
         address_reg     <= '0;
         byte_enable_reg <= '0;
         wdata_reg       <= '0;
         owned_reg       <= 1'b0;
         wd_count_reg    <= '0;
         rsp_rdata_reg   <= '0;
         rsp_status_reg  <= STATUS_OK;
      end else begin
         state_reg      <= state_next;
         owned_reg      <= owned_next;
         wd_count_reg   <= wd_count_next;
         rsp_rdata_reg  <= rsp_rdata_next;
         rsp_status_reg <= rsp_status_next;
         if (accept) begin
            read_reg        <= cmd_read;
            address_reg     <= cmd_address;
            byte_enable_reg <= cmd_byte_enable;
            wdata_reg       <= cmd_wdata;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      owned_next      = owned_reg;
      wd_count_next   = wd_count_reg;
      rsp_rdata_next  = rsp_rdata_reg;
      rsp_status_next = rsp_status_reg;

      case (state_reg)
         IDLE: begin
            if (cmd_valid) state_next = cmd_read ? ISSUE : BUF_WRITE;
         end
         BUF_WRITE: begin
            state_next = ISSUE;
         end
         ISSUE: begin
            owned_next    = 1'b0;
            wd_count_next = '0;
            state_next    = read_reg ? WAIT_RD : WAIT_WR;
         end
         WAIT_WR, WAIT_RD: begin
            if (dma_request && dma_granted) owned_next = 1'b1;
            if (wd_count_reg != 16'hFFFF) wd_count_next = wd_count_reg + 16'd1;

            // Bus error outranks a same-cycle completion, which outranks
            // the watchdog.
            if (bus_error && owned_reg) begin
               rsp_status_next = STATUS_BUS_ERR;
               rsp_rdata_next  = '0;
               state_next      = RESPOND;
            end else if (completion) begin
               rsp_status_next = STATUS_OK;
               rsp_rdata_next  = (state_reg == WAIT_RD) ? dma_buf_wdata : 32'd0;
               state_next      = RESPOND;
            end else if (timeout_hit) begin
               rsp_status_next = STATUS_TIMEOUT;
               rsp_rdata_next  = '0;
               state_next      = RESPOND;
            end
         end
         RESPOND: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign cmd_ready       = (state_reg == IDLE);
   assign rsp_valid       = (state_reg == RESPOND);
   assign rsp_rdata       = rsp_rdata_reg;
   assign rsp_status      = rsp_status_reg;
   assign buf_address     = 9'd0;
   assign buf_we          = (state_reg == BUF_WRITE);
   assign buf_wdata       = buf_we ? wdata_reg : 32'd0;
   assign dma_data_ready  = (state_reg == ISSUE) && !read_reg;
   assign dma_read_ready  = (state_reg == ISSUE) && read_reg;
   assign dma_address     = address_reg;
   assign dma_byte_enable = byte_enable_reg;

endmodule

// File: tb/tb_dma_command_unit.sv
// -----------------------------------------------------------------------------
// tb_dma_command_unit
//
// Self-checking bench for dma_command_unit (TIMEOUT_CYCLES = 16). Expected
// responses are queued when a command is driven and compared by a monitor
// when the response handshake happens. Cycle-exact timing checks are made
// inline by the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_dma_command_unit;

   logic        clock;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_read;
   logic [31:0] cmd_address;
   logic [3:0]  cmd_byte_enable;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic [8:0]  buf_address;
   logic [31:0] buf_wdata;
   logic        buf_we;
   logic        dma_data_ready;
   logic        dma_read_ready;
   logic [31:0] dma_address;
   logic [3:0]  dma_byte_enable;
   logic        dma_buf_we;
   logic [31:0] dma_buf_wdata;
   logic        dma_request;
   logic        dma_granted;
   logic        bus_end_transaction;
   logic        bus_error;

   typedef struct packed {
      logic [1:0]  status;
      logic [31:0] rdata;
   } rsp_t;

   rsp_t sb_queue[$];
   int   vectors     = 0;
   int   miscompares = 0;

   dma_command_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clock               (clock),
      .reset               (reset),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .cmd_read            (cmd_read),
      .cmd_address         (cmd_address),
      .cmd_byte_enable     (cmd_byte_enable),
      .cmd_wdata           (cmd_wdata),
      .rsp_valid           (rsp_valid),
      .rsp_ready           (rsp_ready),
      .rsp_rdata           (rsp_rdata),
      .rsp_status          (rsp_status),
      .buf_address         (buf_address),
      .buf_wdata           (buf_wdata),
      .buf_we              (buf_we),
      .dma_data_ready      (dma_data_ready),
      .dma_read_ready      (dma_read_ready),
      .dma_address         (dma_address),
      .dma_byte_enable     (dma_byte_enable),
      .dma_buf_we          (dma_buf_we),
      .dma_buf_wdata       (dma_buf_wdata),
      .dma_request         (dma_request),
      .dma_granted         (dma_granted),
      .bus_end_transaction (bus_end_transaction),
      .bus_error           (bus_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Offer a command and return one cycle after the accepting edge.
   task automatic send_cmd(input logic rd, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
      int budget;
      cmd_valid       = 1'b1;
      cmd_read        = rd;
      cmd_address     = addr;
      cmd_byte_enable = be;
      cmd_wdata       = wd;
      budget          = 0;
      while (!cmd_ready && budget < 20) begin
         tick();
         budget++;
      end
      check_value("cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      $display("cmd %s addr=%h be=%h wdata=%h", rd ? "READ " : "WRITE", addr, be, wd);
   endtask

   // Consume the pending response; the monitor does the payload compare.
   task automatic drain_rsp(input int budget);
      int n = 0;
      while (!rsp_valid && n < budget) begin
         tick();
         n++;
      end
      check_value("rsp_wait", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      check_value({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check_value({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check_value({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
      check_value({tag, "_buf_we"}, 32'(buf_we), 32'd0);
      check_value({tag, "_buf_wdata"}, buf_wdata, 32'd0);
      check_value({tag, "_dma_trig"}, 32'({dma_data_ready, dma_read_ready}), 32'd0);
      check_value({tag, "_dma_address"}, dma_address, 32'd0);
      check_value({tag, "_dma_be"}, 32'(dma_byte_enable), 32'd0);
   endtask

   // Response monitor and always-on invariants, sampled mid-cycle.
   always @(negedge clock) begin
      if (reset) begin
         check_value("trig_exclusive", 32'(dma_data_ready & dma_read_ready), 32'd0);
         check_value("buf_address", 32'(buf_address), 32'd0);
         if (!buf_we) check_value("buf_wdata_idle", buf_wdata, 32'd0);
         if (rsp_valid && rsp_ready) begin
            if (sb_queue.size() == 0) begin
               check_value("rsp_unexpected", 32'(sb_queue.size()), 32'd1);
            end else begin
               rsp_t exp_rsp;
               exp_rsp = sb_queue.pop_front();
               $display("rsp status=%b rdata=%h (expect status=%b rdata=%h)",
                        rsp_status, rsp_rdata, exp_rsp.status, exp_rsp.rdata);
               check_value("rsp_status", 32'(rsp_status), 32'(exp_rsp.status));
               check_value("rsp_rdata", rsp_rdata, exp_rsp.rdata);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      cmd_valid = 1'b0; cmd_read = 1'b0; cmd_address = '0;
      cmd_byte_enable = '0; cmd_wdata = '0; rsp_ready = 1'b0;
      dma_buf_we = 1'b0; dma_buf_wdata = '0; dma_request = 1'b0;
      dma_granted = 1'b0; bus_end_transaction = 1'b0; bus_error = 1'b0;
      tick();
      tick();
      check_reset_outputs("por");
      reset = 1'b1;
      tick();
      check_value("por_release_cmd_ready", 32'(cmd_ready), 32'd1);

      // Write: grant 3 cycles after request, end 2 cycles after grant.
      sb_queue.push_back('{status: 2'b00, rdata: 32'd0});
      send_cmd(1'b0, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF);
      check_value("wr_buf_we", 32'(buf_we), 32'd1);
      check_value("wr_buf_wdata", buf_wdata, 32'hDEAD_BEEF);
      check_value("wr_early_trig", 32'(dma_data_ready), 32'd0);
      tick();
      check_value("wr_data_ready", 32'(dma_data_ready), 32'd1);
      check_value("wr_dma_address", dma_address, 32'h4000_0010);
      check_value("wr_dma_be", 32'(dma_byte_enable), 32'hF);
      tick();
      check_value("wr_trig_one_cycle", 32'(dma_data_ready), 32'd0);
      dma_request = 1'b1;
      repeat (3) tick();
      dma_granted = 1'b1;
      repeat (2) tick();
      bus_end_transaction = 1'b1;
      check_value("wr_no_early_rsp", 32'(rsp_valid), 32'd0);
      tick();
      bus_end_transaction = 1'b0; dma_request = 1'b0; dma_granted = 1'b0;
      check_value("wr_rsp_rise", 32'(rsp_valid), 32'd1);
      drain_rsp(4);

      // Read with 4 cycles of response backpressure.
      sb_queue.push_back('{status: 2'b00, rdata: 32'h1234_5678});
      send_cmd(1'b1, 32'h4000_0020, 4'hF, 32'h0);
      check_value("rd_read_ready", 32'(dma_read_ready), 32'd1);
      check_value("rd_no_buf_we", 32'(buf_we), 32'd0);
      tick();
      dma_request = 1'b1; dma_granted = 1'b1;
      repeat (6) tick();
      dma_buf_we = 1'b1; dma_buf_wdata = 32'h1234_5678;
      tick();
      dma_buf_we = 1'b0; dma_buf_wdata = 32'h0; dma_request = 1'b0; dma_granted = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_value("rd_hold_valid", 32'(rsp_valid), 32'd1);
         check_value("rd_hold_rdata", rsp_rdata, 32'h1234_5678);
         tick();
      end
      drain_rsp(4);

      // Foreign end_transaction must be ignored.
      sb_queue.push_back('{status: 2'b00, rdata: 32'd0});
      send_cmd(1'b0, 32'h4000_0030, 4'h3, 32'hA5A5_A5A5);
      tick();
      tick();
      dma_request = 1'b1;
      tick();
      bus_end_transaction = 1'b1;
      bus_error = 1'b1;
      tick();
      bus_end_transaction = 1'b0;
      bus_error = 1'b0;
      check_value("foreign_end_ignored", 32'(rsp_valid), 32'd0);
      tick();
      check_value("foreign_end_still_idle", 32'(rsp_valid), 32'd0);
      dma_granted = 1'b1;
      repeat (2) tick();
      bus_end_transaction = 1'b1;
      tick();
      bus_end_transaction = 1'b0; dma_request = 1'b0; dma_granted = 1'b0;
      check_value("own_end_rsp", 32'(rsp_valid), 32'd1);
      drain_rsp(4);
      repeat (3) tick();
      check_value("single_rsp", 32'(rsp_valid), 32'd0);

      // Bus error beats a same-cycle buffer write on an owned read.
      sb_queue.push_back('{status: 2'b01, rdata: 32'd0});
      send_cmd(1'b1, 32'h4000_0040, 4'hF, 32'h0);
      tick();
      dma_request = 1'b1; dma_granted = 1'b1;
      repeat (2) tick();
      bus_error = 1'b1; dma_buf_we = 1'b1; dma_buf_wdata = 32'hFFFF_0000;
      tick();
      bus_error = 1'b0; dma_buf_we = 1'b0; dma_buf_wdata = 32'h0;
      dma_request = 1'b0; dma_granted = 1'b0;
      check_value("err_rsp", 32'(rsp_valid), 32'd1);
      drain_rsp(4);

      // Timeout: response exactly 17 cycles after ISSUE.
      sb_queue.push_back('{status: 2'b10, rdata: 32'd0});
      send_cmd(1'b1, 32'h4000_0050, 4'hC, 32'h0);
      check_value("to_issue", 32'(dma_read_ready), 32'd1);
      repeat (16) tick();
      check_value("to_not_yet", 32'(rsp_valid), 32'd0);
      tick();
      check_value("to_at_17", 32'(rsp_valid), 32'd1);
      check_value("to_status", 32'(rsp_status), 32'd2);
      drain_rsp(4);

      // Reset in WAIT_RD drops the command silently.
      send_cmd(1'b1, 32'h4000_0060, 4'h5, 32'h0);
      tick();
      dma_request = 1'b1; dma_granted = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      #1;
      dma_request = 1'b0; dma_granted = 1'b0;
      check_reset_outputs("midrst");
      tick();
      reset = 1'b1;
      tick();
      check_value("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (20) tick();
      check_value("midrst_no_rsp", 32'(rsp_valid), 32'd0);

      check_value("sb_empty", 32'(sb_queue.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
